// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller.
// Holds the stall bus width, the hold/release bit values, the three stall patterns
// driven onto the bus, the controller state encoding and the mul/div counter load helper.
package pipe_stall_ctrl_pkg;

  // One hold bit per stage: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
  localparam int unsigned StallBus = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // No hold anywhere.
  localparam logic [StallBus-1:0] StallNone = {StallBus{NoStop}};
  // Load-use hazard: freeze PC, IF/ID and ID/EX so a bubble enters EX.
  localparam logic [StallBus-1:0] StallId   = {{3{NoStop}}, {3{Stop}}};
  // Multi-cycle EX op: additionally freeze EX/MEM; MEM and WB keep draining.
  localparam logic [StallBus-1:0] StallEx   = {{2{NoStop}}, {4{Stop}}};

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StMdRun  = 2'b01,
    StMdDone = 2'b10
  } md_state_e;

  // Counter preload for a new mul/div: total hold is N cycles, the start cycle is one of them.
  function automatic logic [5:0] md_load_val(input logic op, input int unsigned mul_cycles,
                                             input int unsigned div_cycles);
    int unsigned n;
    n = op ? div_cycles : mul_cycles;
    return 6'(n - 1);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller.
// Combines load-use hazard requests from ID with multi-cycle mul/div sequencing in EX and
// drives a per-stage hold bus. EX requests win over ID requests. Also keeps a saturating
// count of cycles in which any stage was held.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   stallreq_id  load-use hazard request from ID
//   md_req       EX holds a mul/div instruction (level, held until md_done)
//   md_op        0 = multiply, 1 = divide; only looked at when md_start is high
//   stall        per-stage hold bus (see package for bit map)
//   md_start     one-cycle launch pulse for the mul/div unit
//   md_busy      high while the operation is running
//   md_done      one-cycle pulse, result valid and EX may advance
//   stall_cnt    saturating count of cycles with stall != 0
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                md_req,
  input  logic                md_op,
  output logic [StallBus-1:0] stall,
  output logic                md_start,
  output logic                md_busy,
  output logic                md_done,
  output logic [15:0]         stall_cnt
);

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  load_val;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign load_val = md_load_val(md_op, MUL_CYCLES, DIV_CYCLES);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = StallNone;
    md_start = 1'b0;
    md_busy  = 1'b0;
    md_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (md_req) begin
          md_start = 1'b1;
          stall    = StallEx;
          cnt_d    = load_val;
          // A one-cycle op is fully covered by the start cycle itself.
          state_d  = (load_val == 6'd0) ? StMdDone : StMdRun;
        end else if (stallreq_id) begin
          stall = StallId;
        end
      end
      StMdRun: begin
        // StallEx already covers any ID hazard, so stallreq_id is not looked at here.
        stall   = StallEx;
        md_busy = 1'b1;
        cnt_d   = cnt_q - 6'd1;
        if (cnt_q <= 6'd1) begin
          state_d = StMdDone;
        end
      end
      StMdDone: begin
        // md_req is still high from the finishing instruction and must not relaunch.
        md_done = 1'b1;
        state_d = StIdle;
        if (stallreq_id) begin
          stall = StallId;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Reset silences all outputs in the same cycle, even mid-operation.
    if (!rst) begin
      stall    = StallNone;
      md_start = 1'b0;
      md_busy  = 1'b0;
      md_done  = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall != StallNone) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 6'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl with default parameters (MUL 2, DIV 33).
// Each applied vector carries its expected outputs; they go through a scoreboard queue
// and are compared mid-cycle, away from the rising edge.
module tb_pipe_stall_ctrl;

  typedef struct {
    string       name;
    logic        rst;
    logic        id;
    logic        req;
    logic        op;
    logic [5:0]  stall;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
    bit          chk_cnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        md_req;
  logic        md_op;
  logic [5:0]  stall;
  logic        md_start;
  logic        md_busy;
  logic        md_done;
  logic [15:0] stall_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  pipe_stall_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .md_req      (md_req),
    .md_op       (md_op),
    .stall       (stall),
    .md_start    (md_start),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .stall_cnt   (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input string name, input logic r, input logic id, input logic req,
                              input logic op, input logic [5:0] st, input logic s,
                              input logic b, input logic d, input logic [15:0] c,
                              input bit chk);
    vec_t v;
    v.name = name; v.rst = r; v.id = id; v.req = req; v.op = op;
    v.stall = st; v.start = s; v.busy = b; v.done = d; v.cnt = c; v.chk_cnt = chk;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and compare the outputs of that cycle.
  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    rst = v.rst; stallreq_id = v.id; md_req = v.req; md_op = v.op;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check({e.name, ".stall"}, 16'(stall), 16'(e.stall));
    check({e.name, ".md_start"}, 16'(md_start), 16'(e.start));
    check({e.name, ".md_busy"}, 16'(md_busy), 16'(e.busy));
    check({e.name, ".md_done"}, 16'(md_done), 16'(e.done));
    if (e.chk_cnt) check({e.name, ".stall_cnt"}, stall_cnt, e.cnt);
  endtask

  localparam logic [5:0] SN = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;

  initial begin
    int busy_seen;
    int done_seen;
    rst = 1'b0; stallreq_id = 1'b0; md_req = 1'b0; md_op = 1'b0;

    //             name          rst id req op stall st bs dn cnt
    tbl.push_back(mk("reset",      0, 0, 0, 0, SN, 0, 0, 0, 0, 1));
    tbl.push_back(mk("rst_mask",   0, 1, 1, 1, SN, 0, 0, 0, 0, 1));
    tbl.push_back(mk("idle",       1, 0, 0, 0, SN, 0, 0, 0, 0, 1));
    tbl.push_back(mk("id_stall",   1, 1, 0, 0, SI, 0, 0, 0, 0, 1));
    tbl.push_back(mk("id_after",   1, 0, 0, 0, SN, 0, 0, 0, 1, 1));
    tbl.push_back(mk("mul_t0",     1, 0, 1, 0, SE, 1, 0, 0, 1, 1));
    tbl.push_back(mk("mul_t1",     1, 0, 1, 0, SE, 0, 1, 0, 2, 1));
    tbl.push_back(mk("mul_t2",     1, 0, 1, 0, SN, 0, 0, 1, 3, 1));
    tbl.push_back(mk("mul_t3",     1, 0, 0, 0, SN, 0, 0, 0, 3, 1));
    tbl.push_back(mk("prio_t0",    1, 1, 1, 0, SE, 1, 0, 0, 3, 1));
    tbl.push_back(mk("prio_t1",    1, 1, 1, 0, SE, 0, 1, 0, 4, 1));
    tbl.push_back(mk("prio_done",  1, 1, 1, 0, SI, 0, 0, 1, 5, 1));
    tbl.push_back(mk("prio_id",    1, 1, 0, 0, SI, 0, 0, 0, 6, 1));
    tbl.push_back(mk("prio_end",   1, 0, 0, 0, SN, 0, 0, 0, 7, 1));
    tbl.push_back(mk("b2b_a0",     1, 0, 1, 0, SE, 1, 0, 0, 7, 1));
    tbl.push_back(mk("b2b_a1",     1, 0, 1, 0, SE, 0, 1, 0, 8, 1));
    tbl.push_back(mk("b2b_adone",  1, 0, 1, 0, SN, 0, 0, 1, 9, 1));
    tbl.push_back(mk("b2b_b0",     1, 0, 1, 0, SE, 1, 0, 0, 9, 1));
    tbl.push_back(mk("b2b_b1",     1, 0, 1, 0, SE, 0, 1, 0, 10, 1));
    tbl.push_back(mk("b2b_bdone",  1, 0, 1, 0, SN, 0, 0, 1, 11, 1));
    tbl.push_back(mk("b2b_idle",   1, 0, 0, 0, SN, 0, 0, 0, 11, 1));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Divide: start at k=0, busy k=1..32 (ID requests must not change anything), done k=33.
    apply(mk("div_rst", 0, 0, 0, 0, SN, 0, 0, 0, 0, 0));
    busy_seen = 0;
    for (int k = 0; k <= 34; k++) begin
      logic idk;
      idk = (k >= 1 && k <= 32) ? k[0] : 1'b0;
      if (k == 0)
        apply(mk("div_start", 1, 0, 1, 1, SE, 1, 0, 0, 0, 1));
      else if (k <= 32)
        apply(mk($sformatf("div_run%0d", k), 1, idk, 1, 1, SE, 0, 1, 0, 16'(k), 1));
      else if (k == 33)
        apply(mk("div_done", 1, 0, 1, 1, SN, 0, 0, 1, 33, 1));
      else
        apply(mk("div_idle", 1, 0, 0, 0, SN, 0, 0, 0, 33, 1));
      if (md_busy) busy_seen++;
    end
    check("div_busy_cycles", 16'(busy_seen), 16'd32);

    // Reset during a divide: abandoned with no md_done, counters cleared.
    apply(mk("abort_rst", 0, 0, 0, 0, SN, 0, 0, 0, 0, 0));
    apply(mk("abort_start", 1, 0, 1, 1, SE, 1, 0, 0, 0, 1));
    for (int k = 1; k <= 9; k++)
      apply(mk($sformatf("abort_run%0d", k), 1, 0, 1, 1, SE, 0, 1, 0, 16'(k), 1));
    apply(mk("abort_in_rst", 0, 0, 1, 1, SN, 0, 0, 0, 10, 1));
    apply(mk("abort_after", 1, 0, 0, 0, SN, 0, 0, 0, 0, 1));
    done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      apply(mk("abort_quiet", 1, 0, 0, 0, SN, 0, 0, 0, 0, 1));
      if (md_done) done_seen++;
    end
    check("abort_no_done", 16'(done_seen), 16'd0);

    // Saturation: run the counter up to just below the top, then stall 5 more cycles.
    apply(mk("sat_rst", 0, 0, 0, 0, SN, 0, 0, 0, 0, 0));
    repeat (65533) begin
      @(posedge clk);
      #1;
      rst = 1'b1; stallreq_id = 1'b1; md_req = 1'b0;
    end
    apply(mk("sat_pre",  1, 1, 0, 0, SI, 0, 0, 0, 16'hFFFD, 1));
    apply(mk("sat_s2",   1, 1, 0, 0, SI, 0, 0, 0, 16'hFFFE, 1));
    apply(mk("sat_s3",   1, 1, 0, 0, SI, 0, 0, 0, 16'hFFFF, 1));
    apply(mk("sat_s4",   1, 1, 0, 0, SI, 0, 0, 0, 16'hFFFF, 1));
    apply(mk("sat_s5",   1, 1, 0, 0, SI, 0, 0, 0, 16'hFFFF, 1));
    apply(mk("sat_hold", 1, 0, 0, 0, SN, 0, 0, 0, 16'hFFFF, 1));
    apply(mk("sat_idle", 1, 0, 0, 0, SN, 0, 0, 0, 16'hFFFF, 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 2: busy cycles for a multiply (legal range 1..63).
REQ-002 SHALL have parameter DIV_CYCLES, default 33: busy cycles for a divide (legal range 1..63).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; synchronous, active-low (0 = reset).
REQ-006 stallreq_id  in  1  load-use hazard request from ID stage.
REQ-007 md_req  in  1  EX holds a mul/div instruction; level, held until md_done.
REQ-008 md_op  in  1  0 = multiply, 1 = divide; sampled only when md_start is high.
REQ-009 stall  out  `StallBus (6)  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; `Stop = 1.
REQ-010 md_start  out  1  one-cycle pulse that launches the mul/div unit.
REQ-011 md_busy  out  1  high while the controller is in MD_RUN.
REQ-012 md_done  out  1  one-cycle pulse; the result is valid and EX may advance.
REQ-013 stall_cnt  out  16  saturating count of cycles with stall != 0.

Function
REQ-014 The FSM SHALL have states IDLE, MD_RUN and MD_DONE, plus a 6-bit down-counter cnt.
REQ-015 In IDLE with md_req=1, the block SHALL assert md_start and set stall=6'b001111 in the same cycle (combinational).
REQ-016 On that IDLE edge, cnt SHALL load (md_op ? DIV_CYCLES : MUL_CYCLES) - 1 and the FSM SHALL go to MD_RUN; if the loaded value is 0, the FSM SHALL go straight to MD_DONE.
REQ-017 In MD_RUN, the block SHALL drive stall=6'b001111 and md_busy=1, and decrement cnt each cycle; when cnt==1 the next state SHALL be MD_DONE.
REQ-018 In MD_DONE, the block SHALL pulse md_done with no EX-originated stall, then return to IDLE.
REQ-019 md_req SHALL be ignored in MD_DONE, because the same instruction is still presenting it; a new request is honoured from IDLE only.
REQ-020 When the FSM is in IDLE or MD_DONE with stallreq_id=1 and no new EX start, the block SHALL drive stall=6'b000111, holding PC/IF/ID and placing a bubble into EX.
REQ-021 EX requests SHALL have priority: if md_req and stallreq_id coincide in IDLE, stall=6'b001111 and the ID request is re-evaluated in later cycles.
REQ-022 In MD_RUN, stallreq_id SHALL have no additional effect, since 001111 already covers it.
REQ-023 With no request, stall SHALL be 6'b000000; bits 4 and 5 are always 0.
REQ-024 stall_cnt SHALL increment on each clock edge where stall != 0, and saturate at 16'hFFFF with no wrap-around.
REQ-025 Total EX hold SHALL equal exactly the selected cycle count: md_start cycle + MD_RUN cycles = N; md_done follows in cycle N+1.

Reset
REQ-026 While rst=0 at a clock edge, the FSM SHALL go to IDLE and cnt and stall_cnt SHALL clear to 0.
REQ-027 During reset, md_start, md_busy and md_done SHALL be 0 and stall SHALL be 6'b000000 regardless of inputs; this applies equally to a reset arriving mid-MD_RUN, which abandons the operation with no md_done.

Structure
REQ-028 Stall patterns (STALL_NONE, STALL_ID, STALL_EX), state encodings and `StallBus SHALL live in the shared defines header next to `Stop/`NoStop.
REQ-029 The block SHALL be a single module with no sub-module; the saturating counter stays inline.

Verification
REQ-030 Bench SHALL cover: stallreq_id=1 for 1 cycle, FSM idle -> stall=000111 that cycle, 000000 next, stall_cnt=1.
REQ-031 Bench SHALL cover: md_req=1, md_op=0, MUL_CYCLES=2 -> md_start at t0, stall=001111 at t0..t1, md_done at t2 with stall=000000.
REQ-032 Bench SHALL cover: md_req=1, md_op=1, DIV_CYCLES=33 -> md_busy for 32 cycles, md_done at t33, stall_cnt=33.
REQ-033 Bench SHALL cover: md_req and stallreq_id together at t0 -> stall=001111 (not 000111); after md_done, stallreq_id still high -> stall=000111.
REQ-034 Bench SHALL cover: rst=0 at cycle 10 of a divide -> next cycle state IDLE, stall=0, md_busy=0, no md_done pulse, stall_cnt=0.
REQ-035 Bench SHALL cover: stall_cnt preloaded near 16'hFFFF, 5 stall cycles -> holds at 16'hFFFF.
